// File: rtl/mem_access_arbiter_if.sv
// Bundle of the fetch port, data port and RAM side signals around the arbiter.
// The slave view belongs to the arbiter; the master view belongs to requesters and RAM.
interface mem_access_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_rw;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;

  logic        ram_en;
  logic        ram_rw_flag;
  logic [15:0] ram_addr;
  logic [31:0] ram_data_out;
  logic [31:0] ram_data_in;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_rw, dm_addr, dm_wdata,
    input  ram_data_in,
    output if_done, if_rdata,
    output dm_done, dm_rdata,
    output ram_en, ram_rw_flag, ram_addr, ram_data_out,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_rw, dm_addr, dm_wdata,
    output ram_data_in,
    input  if_done, if_rdata,
    input  dm_done, dm_rdata,
    input  ram_en, ram_rw_flag, ram_addr, ram_data_out,
    input  busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch and
// the load/store path; one access in flight, fixed read latency.
module mem_access_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT = 4'(RAM_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        last_dm_reg;
  logic        owner_dm_reg;
  logic        rw_reg;
  logic [15:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] if_rdata_reg;
  logic [31:0] dm_rdata_reg;

  logic grant;
  logic grant_dm;
  logic last_wait;
  logic ram_en;
  logic if_done;
  logic dm_done;
  logic busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Tie goes to whichever port did not own the previous access.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    grant_dm   = 1'b0;
    last_wait  = 1'b0;
    ram_en     = 1'b0;
    if_done    = 1'b0;
    dm_done    = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (bus.if_req || bus.dm_req) begin
          grant      = 1'b1;
          grant_dm   = bus.dm_req && (!bus.if_req || !last_dm_reg);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          last_wait  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if_done    = !owner_dm_reg;
        dm_done    = owner_dm_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= 4'd0;
      last_dm_reg  <= 1'b0;
      owner_dm_reg <= 1'b0;
      rw_reg       <= 1'b0;
      addr_reg     <= 16'd0;
      wdata_reg    <= 32'd0;
      if_rdata_reg <= 32'd0;
      dm_rdata_reg <= 32'd0;
    end else begin
      // Requester fields are frozen here; later changes on the ports are ignored.
      if (grant) begin
        owner_dm_reg <= grant_dm;
        if (grant_dm) begin
          addr_reg  <= bus.dm_addr;
          rw_reg    <= bus.dm_rw;
          wdata_reg <= bus.dm_wdata;
        end else begin
          addr_reg  <= bus.if_addr;
          rw_reg    <= 1'b1;
        end
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= LAT;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (last_wait && rw_reg) begin
        if (owner_dm_reg) begin
          dm_rdata_reg <= bus.ram_data_in;
        end else begin
          if_rdata_reg <= bus.ram_data_in;
        end
      end
      if (state_reg == DONE) begin
        last_dm_reg <= owner_dm_reg;
      end
    end
  end

  assign bus.ram_en       = ram_en;
  assign bus.ram_rw_flag  = rw_reg;
  assign bus.ram_addr     = addr_reg;
  assign bus.ram_data_out = wdata_reg;
  assign bus.if_done      = if_done;
  assign bus.dm_done      = dm_done;
  assign bus.if_rdata     = if_rdata_reg;
  assign bus.dm_rdata     = dm_rdata_reg;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Random requests and RAM data checked cycle by cycle against a transaction
// timeline model built from grant time plus fixed latency offsets.
module tb_mem_access_arbiter;
  localparam int LAT    = 3;
  localparam int CYCLES = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_arbiter_if bus();

  mem_access_arbiter #(.RAM_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  // Reference model: each access is a grant time g with events at fixed offsets.
  int          idle_at, start_c, en_c, smp_c, done_c;
  logic        m_owner_dm, m_last_dm, m_rw;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_if_rdata, m_dm_rdata;

  task automatic model_step(input int c);
    if (rst) begin
      idle_at = c + 1; start_c = -100; en_c = -1; smp_c = -1; done_c = -1;
      m_owner_dm = 0; m_last_dm = 0; m_rw = 0; m_addr = 0; m_wdata = 0;
      m_if_rdata = 0; m_dm_rdata = 0;
    end else begin
      if (c == smp_c && m_rw) begin
        if (m_owner_dm) m_dm_rdata = bus.ram_data_in;
        else            m_if_rdata = bus.ram_data_in;
      end
      if (c == done_c) m_last_dm = m_owner_dm;
      if (c >= idle_at && (bus.if_req || bus.dm_req)) begin
        m_owner_dm = bus.dm_req && !(bus.if_req && m_last_dm);
        if (m_owner_dm) begin
          m_addr = bus.dm_addr; m_rw = bus.dm_rw; m_wdata = bus.dm_wdata;
        end else begin
          m_addr = bus.if_addr; m_rw = 1'b1;
        end
        start_c = c;
        en_c    = c + 1;
        smp_c   = c + 1 + LAT;
        done_c  = c + 2 + LAT;
        idle_at = c + 3 + LAT;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_rw = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.ram_data_in = 0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      if (c > 0) begin
        check("ram_en",   c, 32'(bus.ram_en),      32'(c == en_c));
        check("ram_addr", c, 32'(bus.ram_addr),    32'(m_addr));
        check("ram_rw",   c, 32'(bus.ram_rw_flag), 32'(m_rw));
        if (c == en_c && !m_rw) check("ram_wdata", c, bus.ram_data_out, m_wdata);
        check("if_done",  c, 32'(bus.if_done), 32'(c == done_c && !m_owner_dm));
        check("dm_done",  c, 32'(bus.dm_done), 32'(c == done_c && m_owner_dm));
        check("if_rdata", c, bus.if_rdata, m_if_rdata);
        check("dm_rdata", c, bus.dm_rdata, m_dm_rdata);
        check("busy",     c, 32'(bus.busy), 32'(c > start_c && c < idle_at));
        if (c == done_c)
          $display("txn cyc=%0d port=%s rw=%0d addr=%h rdata=%h", c,
                   m_owner_dm ? "dm" : "if", m_rw, m_addr,
                   m_owner_dm ? m_dm_rdata : m_if_rdata);
      end
      // Stimulus for this cycle: reset phase, both-held phase, then random mixes.
      if (c < 5) begin
        rst = 1'b1;
      end else begin
        rst = ($urandom_range(0, 249) == 0);
      end
      if (c < 80) begin
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
      end else if (c < 2000) begin
        bus.if_req = ($urandom_range(0, 3) != 0);
        bus.dm_req = ($urandom_range(0, 3) != 0);
      end else begin
        bus.if_req = ($urandom_range(0, 7) == 0);
        bus.dm_req = ($urandom_range(0, 7) == 0);
      end
      bus.if_addr     = 16'($urandom);
      bus.dm_addr     = 16'($urandom);
      bus.dm_rw       = 1'($urandom);
      bus.dm_wdata    = $urandom;
      bus.ram_data_in = $urandom;
      model_step(c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
